// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit working beside the EX stage.
// Holds the pipeline while busy, returns result plus destination tag, and aborts on flush.
module ex_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       reg1_i,
    input  logic [XLEN-1:0]       reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);
    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = XLEN / B;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int XB    = XLEN + B;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_op;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg_lat;
    logic                  r_neg;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_hi, r_lo, r_opb;

    logic                  w_accept, w_a_signed, w_b_signed, w_neg_a, w_neg_b, w_res_neg;
    logic                  w_div0, w_ovf, w_special;
    logic [XLEN-1:0]       w_mag_a, w_mag_b, w_spec_res;
    logic [XB-1:0]         w_mpart, w_psum;
    logic [2*XLEN-1:0]     w_mul_p, w_prod;
    logic [XLEN:0]         w_drem;
    logic [XLEN-1:0]       w_dquo, w_quo_s, w_rem_s, w_hi_nxt, w_lo_nxt, w_calc_res;
    logic                  w_done_nxt, w_wreg_nxt;
    logic [XLEN-1:0]       w_wdata_nxt;
    logic [REG_ADDR_W-1:0] w_wd_nxt;

    assign w_accept   = (r_state == S_IDLE) & start_i & ~flush_i;
    assign w_a_signed = (op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_b_signed = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_neg_a    = w_a_signed & reg1_i[XLEN-1];
    assign w_neg_b    = w_b_signed & reg2_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? -reg1_i : reg1_i;
    assign w_mag_b    = w_neg_b ? -reg2_i : reg2_i;
    assign w_res_neg  = (op_i == OP_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);
    assign w_div0     = op_i[2] & (reg2_i == {XLEN{1'b0}});
    assign w_ovf      = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                        (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) & (reg2_i == {XLEN{1'b1}});
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (op_i[1] ? reg1_i : {XLEN{1'b1}})
                               : (op_i[1] ? {XLEN{1'b0}} : reg1_i);

    assign stall_req_o = w_accept | (r_state == S_CALC);

    // One CALC step: B shift-add multiplier digits, or B restoring-divide quotient bits
    always_comb begin
        w_mpart = XB'(r_opb) * XB'(r_lo[B-1:0]);
        w_psum  = XB'(r_hi) + w_mpart;
        w_mul_p = {w_psum, r_lo[XLEN-1:B]};
        w_drem  = {1'b0, r_hi};
        w_dquo  = r_lo;
        for (int i = 0; i < B; i++) begin
            w_drem = {w_drem[XLEN-1:0], w_dquo[XLEN-1]};
            w_dquo = {w_dquo[XLEN-2:0], 1'b0};
            if (w_drem >= {1'b0, r_opb}) begin
                w_drem    = w_drem - {1'b0, r_opb};
                w_dquo[0] = 1'b1;
            end else begin
                w_dquo[0] = 1'b0;
            end
        end
    end

    // Sign correction and result selection for the final CALC step
    always_comb begin
        w_hi_nxt = r_op[2] ? w_drem[XLEN-1:0] : w_mul_p[2*XLEN-1:XLEN];
        w_lo_nxt = r_op[2] ? w_dquo : w_mul_p[XLEN-1:0];
        w_prod   = r_neg ? -w_mul_p : w_mul_p;
        w_quo_s  = r_neg ? -w_dquo : w_dquo;
        w_rem_s  = r_neg ? -w_drem[XLEN-1:0] : w_drem[XLEN-1:0];
        case (r_op)
            OP_MUL:                       w_calc_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_calc_res = w_quo_s;
            OP_REM, OP_REMU:              w_calc_res = w_rem_s;
            default:                      w_calc_res = {XLEN{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; flush wins over start and over completion
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered result interface
    always_comb begin
        w_done_nxt = (w_state_nxt == S_DONE);
        if (r_state == S_IDLE) begin
            w_wreg_nxt  = w_done_nxt & wreg_i;
            w_wd_nxt    = wd_i;
            w_wdata_nxt = w_spec_res;
        end else begin
            w_wreg_nxt  = w_done_nxt & r_wreg_lat;
            w_wd_nxt    = r_wd;
            w_wdata_nxt = w_calc_res;
        end
    end

    // Registered result interface; data and tag hold between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_o  <= 1'b0;
            wreg_o  <= 1'b0;
            wdata_o <= {XLEN{1'b0}};
            wd_o    <= {REG_ADDR_W{1'b0}};
        end else if (rdy) begin
            done_o <= w_done_nxt;
            wreg_o <= w_wreg_nxt;
            if (w_done_nxt) begin
                wdata_o <= w_wdata_nxt;
                wd_o    <= w_wd_nxt;
            end
        end
    end

    // Operand latch on accept and iterative datapath update during CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 3'b000;
            r_wd       <= {REG_ADDR_W{1'b0}};
            r_wreg_lat <= 1'b0;
            r_neg      <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
            r_hi       <= {XLEN{1'b0}};
            r_lo       <= {XLEN{1'b0}};
            r_opb      <= {XLEN{1'b0}};
        end else if (rdy) begin
            if (w_accept) begin
                r_op       <= op_i;
                r_wd       <= wd_i;
                r_wreg_lat <= wreg_i;
                r_neg      <= w_res_neg;
                r_cnt      <= {CNT_W{1'b0}};
                r_hi       <= {XLEN{1'b0}};
                r_lo       <= w_mag_a;
                r_opb      <= w_mag_b;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
            end
        end
    end
endmodule
